// File: rtl/soccer_pkg.sv
// Shared constants and helpers for the score/timer overlay blocks.
//   GLYPH_W/GLYPH_H   : font cell size in unscaled pixels
//   ASCII_ZERO/QMARK  : character codes used by the digit renderer
//   BLINK_PERIOD/ON   : time-over blink cycle in frames (60 Hz frame rate)
//   digit_sel_e       : which countdown digit a pixel column falls on
//   digit_char()      : BCD digit to font character code ('?' for non-BCD)
package soccer_pkg;

  localparam int unsigned GLYPH_W      = 8;
  localparam int unsigned GLYPH_H      = 16;
  localparam logic [6:0]  ASCII_ZERO   = 7'h30;
  localparam logic [6:0]  ASCII_QMARK  = 7'h3F;
  localparam logic [5:0]  BLINK_PERIOD = 6'd60;
  localparam logic [5:0]  BLINK_ON     = 6'd30;

  typedef enum logic [1:0] {
    DIG_HUNDREDS = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_ONES     = 2'd2,
    DIG_NONE     = 2'd3
  } digit_sel_e;

  function automatic logic [6:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_QMARK : ASCII_ZERO + {3'b000, d};
  endfunction

endpackage

// File: rtl/timer_digit_renderer_if.sv
// Font ROM bus between the digit renderer and the external synchronous ROM.
//   rom_addr : {char[6:0], row[3:0]}, driven by the renderer
//   rom_data : glyph row, valid one cycle after rom_addr, MSB = leftmost pixel
interface timer_digit_renderer_if;

  logic [10:0] rom_addr;
  logic [7:0]  rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/digit_snapshot.sv
// Frame-latched countdown digits and time-over blink state.
//   clk25, reset_n       : pixel clock, async active-low reset
//   frame_start          : one-cycle pulse at start of vertical blank
//   hundreds/tens/ones   : live BCD digits (asynchronous to the frame)
//   time_over            : live countdown-expired level
//   snap_hundreds/...    : digits held for the whole frame
//   visible              : digits are shown this frame
module digit_snapshot
  import soccer_pkg::*;
(
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       time_over,
  output logic [3:0] snap_hundreds,
  output logic [3:0] snap_tens,
  output logic [3:0] snap_ones,
  output logic       visible
);

  logic       snap_time_over;
  logic [5:0] blink_count;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      snap_hundreds  <= '0;
      snap_tens      <= '0;
      snap_ones      <= '0;
      snap_time_over <= 1'b0;
      blink_count    <= '0;
    end else if (frame_start) begin
      snap_hundreds  <= hundreds;
      snap_tens      <= tens;
      snap_ones      <= ones;
      snap_time_over <= time_over;
      // Count only from the second expired frame on, so the first expired
      // frame sits at count 0 and is shown.
      if (time_over && snap_time_over)
        blink_count <= (blink_count == BLINK_PERIOD - 6'd1) ? '0 : blink_count + 6'd1;
      else
        blink_count <= '0;
    end
  end

  assign visible = !snap_time_over || (blink_count < BLINK_ON);

endmodule

// File: rtl/timer_digit_renderer.sv
// Renders the three-digit match countdown as glyph pixels for the colour
// mapper. Fixed 3-cycle latency from drawX/drawY to text_on, one pixel/cycle.
//   clk25, reset_n      : pixel clock, async active-low reset
//   frame_start         : latches digits/time_over for the coming frame
//   hundreds/tens/ones  : BCD countdown digits
//   time_over           : countdown expired; digits blink at 1 Hz
//   drawX, drawY        : current pixel coordinates
//   rom                 : font ROM bus (master side)
//   text_on             : lit glyph pixel, 3 cycles after the coordinates
module timer_digit_renderer
  import soccer_pkg::*;
#(
  parameter logic [9:0]  X_ORIGIN   = 10'd280,
  parameter logic [9:0]  Y_ORIGIN   = 10'd8,
  parameter int unsigned SCALE_LOG2 = 1
) (
  input  logic                          clk25,
  input  logic                          reset_n,
  input  logic                          frame_start,
  input  logic [3:0]                    hundreds,
  input  logic [3:0]                    tens,
  input  logic [3:0]                    ones,
  input  logic                          time_over,
  input  logic [9:0]                    drawX,
  input  logic [9:0]                    drawY,
  timer_digit_renderer_if.master        rom,
  output logic                          text_on
);

  localparam logic [9:0] BOX_W = 10'((3 * GLYPH_W) << SCALE_LOG2);
  localparam logic [9:0] BOX_H = 10'(GLYPH_H << SCALE_LOG2);

  logic [3:0] snap_hundreds, snap_tens, snap_ones;
  logic       visible;

  digit_snapshot u_snapshot (
    .clk25         (clk25),
    .reset_n       (reset_n),
    .frame_start   (frame_start),
    .hundreds      (hundreds),
    .tens          (tens),
    .ones          (ones),
    .time_over     (time_over),
    .snap_hundreds (snap_hundreds),
    .snap_tens     (snap_tens),
    .snap_ones     (snap_ones),
    .visible       (visible)
  );

  logic [9:0] dx, dy, gx, gy;
  logic       in_box;
  digit_sel_e digit_sel;
  logic [3:0] digit;
  logic [6:0] char_code;

  // Unsigned wrap puts pixels left of/above the origin far outside the box.
  always_comb begin
    dx        = drawX - X_ORIGIN;
    dy        = drawY - Y_ORIGIN;
    in_box    = (dx < BOX_W) && (dy < BOX_H);
    gx        = dx >> SCALE_LOG2;
    gy        = dy >> SCALE_LOG2;
    digit_sel = digit_sel_e'(gx[4:3]);
    case (digit_sel)
      DIG_HUNDREDS: digit = snap_hundreds;
      DIG_TENS:     digit = snap_tens;
      default:      digit = snap_ones;
    endcase
    char_code = digit_char(digit);
  end

  logic       in_box_d1, in_box_d2;
  logic [2:0] col_d1, col_d2;
  logic       visible_d1, visible_d2;

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      rom.rom_addr <= '0;
      in_box_d1    <= 1'b0;
      col_d1       <= '0;
      visible_d1   <= 1'b0;
      in_box_d2    <= 1'b0;
      col_d2       <= '0;
      visible_d2   <= 1'b0;
      text_on      <= 1'b0;
    end else begin
      if (in_box)
        rom.rom_addr <= {char_code, gy[3:0]};
      in_box_d1  <= in_box;
      col_d1     <= gx[2:0];
      visible_d1 <= visible;
      // Stage 2 lines up with rom_data returned by the synchronous ROM.
      in_box_d2  <= in_box_d1;
      col_d2     <= col_d1;
      visible_d2 <= visible_d1;
      text_on    <= in_box_d2 && rom.rom_data[3'd7 - col_d2] && visible_d2;
    end
  end

  // Only the in-box range of the scaled offsets is meaningful.
  logic unused_bits;
  assign unused_bits = ^{gx[9:5], gy[9:4]};

endmodule

// File: tb/tb_timer_digit_renderer.sv
module tb_timer_digit_renderer;

  localparam logic [9:0] XO = 10'd280;
  localparam logic [9:0] YO = 10'd8;
  localparam int XI = 280;
  localparam int YI = 8;

  logic       clk25 = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] hundreds = '0, tens = '0, ones = '0;
  logic       time_over = 1'b0;
  logic [9:0] drawX = '0, drawY = '0;
  logic       text_on;

  timer_digit_renderer_if rom_bus ();

  timer_digit_renderer #(
    .X_ORIGIN   (XO),
    .Y_ORIGIN   (YO),
    .SCALE_LOG2 (1)
  ) dut (
    .clk25       (clk25),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .hundreds    (hundreds),
    .tens        (tens),
    .ones        (ones),
    .time_over   (time_over),
    .drawX       (drawX),
    .drawY       (drawY),
    .rom         (rom_bus),
    .text_on     (text_on)
  );

  always #20 clk25 = ~clk25;

  // Deterministic font contents: distinct rows per character.
  function automatic logic [7:0] font_row(input logic [6:0] c, input logic [3:0] r);
    logic [7:0] v;
    v = 8'({1'b0, c} * 8'd37) ^ 8'({4'b0000, r} * 8'd19) ^ 8'h5A;
    return v;
  endfunction

  always @(posedge clk25)
    rom_bus.rom_data <= font_row(rom_bus.rom_addr[10:4], rom_bus.rom_addr[3:0]);

  // Reference pixel model: 2x magnified 24x16 box of three glyphs.
  function automatic logic exp_px(input int x, input int y, input logic [3:0] h,
                                  input logic [3:0] t, input logic [3:0] o, input logic vis);
    int lx, ly, d;
    logic [3:0] dig;
    logic [6:0] ch;
    logic [7:0] bits;
    if (x < XI || x >= XI + 48 || y < YI || y >= YI + 32) return 1'b0;
    lx = (x - XI) / 2;
    ly = (y - YI) / 2;
    d = lx / 8;
    dig = (d == 0) ? h : (d == 1) ? t : o;
    ch = (dig > 4'd9) ? 7'h3F : 7'(48 + int'(dig));
    bits = font_row(ch, 4'(ly));
    return vis & bits[7 - (lx % 8)];
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct { logic e; int x; int y; } exp_t;
  exp_t        txt_q[$];
  logic [10:0] addr_q[$];
  logic        issue = 1'b0, addr_issue = 1'b0;
  logic [2:0]  vsr = '0;
  logic        asr = 1'b0;

  always @(posedge clk25) begin
    vsr <= {vsr[1:0], issue};
    asr <= addr_issue;
  end

  // Monitor: pops expectations as the pipelined outputs appear.
  always @(negedge clk25) begin
    exp_t e;
    logic [10:0] ea;
    if (vsr[2]) begin
      if (txt_q.size() == 0) chk("text_q_underflow", 32'd1, 32'd0);
      else begin
        e = txt_q.pop_front();
        chk($sformatf("text_on(%0d,%0d)", e.x, e.y), {31'd0, text_on}, {31'd0, e.e});
      end
    end
    if (asr) begin
      if (addr_q.size() == 0) chk("addr_q_underflow", 32'd1, 32'd0);
      else begin
        ea = addr_q.pop_front();
        chk("rom_addr", {21'd0, rom_bus.rom_addr}, {21'd0, ea});
      end
    end
  end

  logic [3:0] m_h = '0, m_t = '0, m_o = '0;
  logic       m_vis = 1'b1;

  task automatic px(input int x, input int y, input logic e, input logic ae, input logic [10:0] ea);
    @(negedge clk25);
    drawX = 10'(x);
    drawY = 10'(y);
    issue = 1'b1;
    addr_issue = ae;
    txt_q.push_back('{e, x, y});
    if (ae) addr_q.push_back(ea);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk25);
      issue = 1'b0;
      addr_issue = 1'b0;
    end
  endtask

  task automatic scan(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        px(x, y, exp_px(x, y, m_h, m_t, m_o, m_vis), 1'b0, '0);
  endtask

  task automatic frame(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                       input logic to, input logic vis);
    @(negedge clk25);
    issue = 1'b0;
    addr_issue = 1'b0;
    hundreds = h; tens = t; ones = o; time_over = to;
    frame_start = 1'b1;
    @(negedge clk25);
    frame_start = 1'b0;
    m_h = h; m_t = t; m_o = o; m_vis = vis;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1;
    logic [7:0] fr;
    r1 = -1;
    for (int r = 0; r < 16; r++) begin
      fr = font_row(7'h31, 4'(r));
      if (r1 < 0 && fr[7]) r1 = r;
    end
    if (r1 < 0) r1 = 0;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    chk("reset_text_on", {31'd0, text_on}, 32'd0);
    chk("reset_rom_addr", {21'd0, rom_bus.rom_addr}, 32'd0);
    repeat (3) @(negedge clk25);
    reset_n = 1'b1;

    // "180" bitmap at 2x, with a margin around the box
    frame(4'd1, 4'd8, 4'd0, 1'b0, 1'b1);
    scan(XI - 2, XI + 49, YI - 1, YI + 32);
    px(XI, YI, exp_px(XI, YI, m_h, m_t, m_o, m_vis), 1'b1, {7'h31, 4'd0});
    px(XI + 16, YI + 2, exp_px(XI + 16, YI + 2, m_h, m_t, m_o, m_vis), 1'b1, {7'h38, 4'd1});
    px(XI + 47, YI + 31, exp_px(XI + 47, YI + 31, m_h, m_t, m_o, m_vis), 1'b1, {7'h30, 4'd15});

    // Horizontal box edges on a row where the '1' glyph MSB is lit
    px(XI - 1, YI + 2 * r1, 1'b0, 1'b0, '0);
    px(XI + 48, YI + 2 * r1, 1'b0, 1'b0, '0);
    px(XI, YI + 2 * r1, 1'b1, 1'b0, '0);
    idle(4);

    // Mid-frame digit change must not show until the next frame
    ones = 4'd9;
    scan(XI + 32, XI + 47, YI, YI + 31);
    frame(4'd1, 4'd8, 4'd9, 1'b0, 1'b1);
    scan(XI + 32, XI + 47, YI, YI + 31);

    // Non-BCD digit renders as '?'
    frame(4'hC, 4'd8, 4'd9, 1'b0, 1'b1);
    px(XI, YI, exp_px(XI, YI, m_h, m_t, m_o, m_vis), 1'b1, {7'h3F, 4'd0});
    px(XI + 1, YI + 5, exp_px(XI + 1, YI + 5, m_h, m_t, m_o, m_vis), 1'b1, {7'h3F, 4'd2});
    px(XI + 20, YI + 5, exp_px(XI + 20, YI + 5, m_h, m_t, m_o, m_vis), 1'b1, {7'h38, 4'd2});
    idle(4);

    // Time over: blink 30 frames on, 30 off ('0' row 0 MSB is lit)
    for (int k = 0; k < 120; k++) begin
      frame(4'd0, 4'd0, 4'd0, 1'b1, ((k % 60) < 30));
      px(XI, YI, ((k % 60) < 30), 1'b0, '0);
      px(XI + 33, YI + 1, ((k % 60) < 30), 1'b0, '0);
      px(XI - 1, YI, 1'b0, 1'b0, '0);
    end
    frame(4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    px(XI, YI, 1'b1, 1'b0, '0);
    px(XI + 33, YI + 1, 1'b1, 1'b0, '0);
    for (int k = 0; k < 31; k++) begin
      frame(4'd0, 4'd0, 4'd0, 1'b1, (k < 30));
      if (k == 0 || k >= 29) begin
        px(XI, YI, (k < 30), 1'b0, '0);
        px(XI + 16, YI, (k < 30), 1'b0, '0);
      end
    end
    idle(4);

    // Asynchronous reset mid-scan
    frame(4'd1, 4'd8, 4'd9, 1'b0, 1'b1);
    repeat (4) px(XI, YI + 2 * r1, 1'b1, 1'b0, '0);
    idle(4);
    chk("hold_text_on", {31'd0, text_on}, 32'd1);
    #5 reset_n = 1'b0;
    #1;
    chk("async_reset_text_on", {31'd0, text_on}, 32'd0);
    chk("async_reset_rom_addr", {21'd0, rom_bus.rom_addr}, 32'd0);
    repeat (2) @(negedge clk25);
    reset_n = 1'b1;
    m_h = '0; m_t = '0; m_o = '0; m_vis = 1'b1;
    scan(XI, XI + 47, YI, YI + 31);
    px(XI, YI, exp_px(XI, YI, m_h, m_t, m_o, m_vis), 1'b1, {7'h30, 4'd0});
    frame(4'd1, 4'd8, 4'd9, 1'b0, 1'b1);
    px(XI, YI + 2 * r1, 1'b1, 1'b0, '0);
    px(XI, YI, exp_px(XI, YI, m_h, m_t, m_o, m_vis), 1'b1, {7'h31, 4'd0});
    idle(6);

    chk("scoreboard_drained", 32'(txt_q.size() + addr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_digit_renderer.md
# timer_digit_renderer

Renders the three-digit match countdown (hundreds/tens/ones BCD from the timekeeping block) as pixels for the VGA colour mapper. The block latches the digits once per frame to prevent mid-frame tearing. It drives a synchronous font ROM and returns a per-pixel `text_on` aligned to a fixed 3-cycle latency. Once time is over, the digits blink at 1 Hz (60 Hz frame rate).

## Interface
Parameters:
- `X_ORIGIN`, 10'd280: left edge of the digit box, in pixels.
- `Y_ORIGIN`, 10'd8: top edge of the digit box.
- `SCALE_LOG2`, 1: glyph magnification is 2^SCALE_LOG2 (0, 1 or 2).

Ports:
- `clk25`  in  1  25 MHz pixel clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse at the start of vertical blank.
- `hundreds`, `tens`, `ones`  in  4 each  BCD countdown digits; asynchronous to the frame.
- `time_over`  in  1  level; high when the countdown has expired.
- `drawX`, `drawY`  in  10 each  current pixel coordinates.
- `rom_addr`  out  11  font ROM address, {char[6:0], row[3:0]}.
- `rom_data`  in  8  font ROM row; valid 1 cycle after `rom_addr`; MSB is the leftmost pixel.
- `text_on`  out  1  high when this pixel is a lit glyph pixel.

## Operation
- Snapshot:
  - On a cycle with `frame_start`=1, register `hundreds`, `tens`, `ones` and `time_over` into snapshot registers.
  - Snapshots hold for the rest of the frame; rendering uses only snapshot values.
- Box geometry:
  - Width W = 24<<SCALE_LOG2; height H = 16<<SCALE_LOG2.
  - `in_box` = (drawX − X_ORIGIN) < W and (drawY − Y_ORIGIN) < H, using unsigned 10-bit subtraction, so coordinates left of or above the origin wrap large and fall outside.
- Glyph select:
  - gx = (drawX − X_ORIGIN) >> SCALE_LOG2, range 0..23. Digit index = gx[4:3] (0 = hundreds, 1 = tens, 2 = ones). Column = gx[2:0].
  - row = ((drawY − Y_ORIGIN) >> SCALE_LOG2)[3:0].
- Character code = 7'h30 + digit. A digit value above 9 renders as 7'h3F ('?').
- Pixel: `text_on` = in_box_d2 & rom_data[7 − col_d2] & visible_d2.
- Blink counter:
  - 6 bits; advances on each `frame_start`, counting 0..59 and wrapping 59→0.
  - Cleared to 0 on any `frame_start` whose newly latched time_over is 0.
  - visible = 1 if snapshot time_over = 0; otherwise visible = (count < 30).
  - The first expired frame is therefore visible (count 0).
- Outside the box, `rom_addr` holds its last value (don't-care for the ROM) and `text_on` = 0.

## Timing
- Pixel sampled at edge N (inputs valid in cycle N):
  - `rom_addr`, in_box_d1, col_d1 and visible_d1 are registered at the end of cycle N.
  - The ROM returns `rom_data` during cycle N+2.
  - `text_on` is registered at the end of cycle N+2 and is valid in cycle N+3.
- Fixed latency is 3 cycles, with no stalls and one pixel per cycle. The colour mapper delays its coordinates by 3.
- `frame_start` and a pixel sample in the same cycle: that pixel uses the pre-update snapshot. This case never happens inside the visible area.
- Reset (asynchronous assert, synchronous deassert through the existing reset path) clears:
  - snapshots to 0 and snapshot time_over to 0;
  - the blink counter to 0;
  - all pipeline registers to 0, so `rom_addr` = 0 and `text_on` = 0.
- A reset mid-frame shows "000" until the next `frame_start`.

## Structure
- Shared package `soccer_pkg` holds:
  - GLYPH_W = 8, GLYPH_H = 16;
  - ASCII_ZERO = 7'h30, ASCII_QMARK = 7'h3F;
  - BLINK_PERIOD = 60, BLINK_ON = 30.
- One sub-module, `digit_snapshot`, contains the frame-latched digit/time_over registers and the blink counter, and outputs `visible`.
- The font ROM is instantiated outside this block.

## Test plan
- Reset, then frame_start with digits 1,8,0 and a behavioural 1-cycle font ROM; scan the box -> bitmap of "180" at 2x, with `text_on` exactly 3 cycles after the coordinates.
- Change `ones` 0→9 mid-frame -> the current frame still shows 0; the next frame after frame_start shows 9.
- drawX = X_ORIGIN−1 and X_ORIGIN+48 (SCALE_LOG2 = 1) -> `text_on` = 0. drawX = X_ORIGIN at a row where the glyph MSB is set -> `text_on` = 1.
- Drive digit 4'hC -> `rom_addr` char field = 7'h3F.
- Assert time_over with digits 0,0,0 over 120 frames -> visible in frames 0–29, blank in 30–59, visible again in 60–89. Deassert time_over -> counter clears and digits stay visible.
- Pulse reset_n low mid-scan -> `text_on` and `rom_addr` are 0 immediately (asynchronous), and "000" is displayed until the next frame_start.
